// File: rtl/aes128_enc_round_ctrl_if.sv
// AES-128 round sequencer control bundle.
// Start/abort/key-ready in, datapath strobes and round index out.
interface aes128_enc_round_ctrl_if;
  logic       start_i;
  logic       abort_i;
  logic       key_rdy_i;
  logic       busy_o;
  logic       ld_pt_o;
  logic       ark_only_o;
  logic       mix_col_o;
  logic       st_en_o;
  logic [3:0] round_o;
  logic       done_o;

  modport master (
    output start_i,
    output abort_i,
    output key_rdy_i,
    input  busy_o,
    input  ld_pt_o,
    input  ark_only_o,
    input  mix_col_o,
    input  st_en_o,
    input  round_o,
    input  done_o
  );

  modport slave (
    input  start_i,
    input  abort_i,
    input  key_rdy_i,
    output busy_o,
    output ld_pt_o,
    output ark_only_o,
    output mix_col_o,
    output st_en_o,
    output round_o,
    output done_o
  );
endinterface

// File: rtl/aes128_enc_round_ctrl.sv
// AES-128 encryption round sequencer.
// Walks LOAD, ARK0, rounds 1..NR-1, final round, then pulses done.
module aes128_enc_round_ctrl #(
  parameter int NR      = 10,
  parameter int RND_LAT = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  aes128_enc_round_ctrl_if.slave       ctl
);

  localparam int CW = $clog2(RND_LAT + 1);
  localparam logic [CW-1:0] LAT_M1 = CW'(RND_LAT - 1);
  localparam logic [3:0] RND_LAST = 4'(NR);
  localparam logic [3:0] RND_PEN  = 4'(NR - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARK0,
    ROUND,
    FINAL,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      round_q, round_d;

  logic busy;
  logic ld_pt;
  logic ark_only;
  logic mix_col;
  logic st_en;
  logic done;
  logic lat_end;

  assign lat_end = (cnt_q == LAT_M1);

  // Next-state, counters and decoded strobes
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    round_d  = round_q;
    busy     = 1'b0;
    ld_pt    = 1'b0;
    ark_only = 1'b0;
    mix_col  = 1'b0;
    st_en    = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        round_d = 4'd0;
        cnt_d   = '0;
        if (ctl.start_i) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        busy    = 1'b1;
        ld_pt   = 1'b1;
        round_d = 4'd0;
        state_d = ARK0;
      end
      ARK0: begin
        busy     = 1'b1;
        ark_only = 1'b1;
        if (ctl.key_rdy_i) begin
          st_en   = 1'b1;
          cnt_d   = '0;
          round_d = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        busy    = 1'b1;
        mix_col = 1'b1;
        if (!lat_end) begin
          cnt_d = cnt_q + CW'(1);
        end else if (ctl.key_rdy_i) begin
          st_en = 1'b1;
          cnt_d = '0;
          if (round_q == RND_PEN) begin
            round_d = RND_LAST;
            state_d = FINAL;
          end else begin
            round_d = round_q + 4'd1;
          end
        end
      end
      FINAL: begin
        busy = 1'b1;
        if (!lat_end) begin
          cnt_d = cnt_q + CW'(1);
        end else if (ctl.key_rdy_i) begin
          st_en   = 1'b1;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        cnt_d   = '0;
        round_d = 4'd0;
        if (ctl.start_i) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        round_d = 4'd0;
      end
    endcase

    // Abort (or reset) wins over every transition and kills the commit
    if (ctl.abort_i || rst_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      round_d = 4'd0;
      st_en   = 1'b0;
    end
  end

  // State, latency counter and round index registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
    end
  end

  assign ctl.busy_o     = busy;
  assign ctl.ld_pt_o    = ld_pt;
  assign ctl.ark_only_o = ark_only;
  assign ctl.mix_col_o  = mix_col;
  assign ctl.st_en_o    = st_en;
  assign ctl.round_o    = round_q;
  assign ctl.done_o     = done;

endmodule

// File: tb/tb_aes128_enc_round_ctrl.sv
// Directed bench for the AES-128 round sequencer.
// Two instances: RND_LAT=1 (a) and RND_LAT=3 (b), NR=10.
module tb_aes128_enc_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes128_enc_round_ctrl_if a_if ();
  aes128_enc_round_ctrl_if b_if ();

  aes128_enc_round_ctrl #(.NR(10), .RND_LAT(1)) u_a (
    .clk_i (clk),
    .rst_i (rst),
    .ctl   (a_if)
  );

  aes128_enc_round_ctrl #(.NR(10), .RND_LAT(3)) u_b (
    .clk_i (clk),
    .rst_i (rst),
    .ctl   (b_if)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int cyc = 0;
  int t0  = 0;
  int k;
  assign k = cyc - t0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] rnd_a [64];
  bit dn_a [64];
  bit st_a [64];
  bit mx_a [64];
  bit bz_a [64];
  bit ld_a [64];
  logic [3:0] rnd_b [64];
  bit dn_b [64];
  bit st_b [64];
  bit mx_b [64];

  always @(negedge clk) begin
    if (k >= 0 && k < 64) begin
      rnd_a[k[5:0]] <= a_if.round_o;
      dn_a[k[5:0]]  <= a_if.done_o;
      st_a[k[5:0]]  <= a_if.st_en_o;
      mx_a[k[5:0]]  <= a_if.mix_col_o;
      bz_a[k[5:0]]  <= a_if.busy_o;
      ld_a[k[5:0]]  <= a_if.ld_pt_o;
      rnd_b[k[5:0]] <= b_if.round_o;
      dn_b[k[5:0]]  <= b_if.done_o;
      st_b[k[5:0]]  <= b_if.st_en_o;
      mx_b[k[5:0]]  <= b_if.mix_col_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cnt1(input bit v [64], input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic int first1(input bit v [64]);
    for (int i = 0; i < 64; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic at(input int c);
    while (cyc - t0 < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_test();
    @(posedge clk);
    #1;
    t0 = cyc;
  endtask

  initial begin
    a_if.start_i   = 1'b0;
    a_if.abort_i   = 1'b0;
    a_if.key_rdy_i = 1'b0;
    b_if.start_i   = 1'b0;
    b_if.abort_i   = 1'b0;
    b_if.key_rdy_i = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(a_if.busy_o), 0);
    chk("rst_round", 32'(a_if.round_o), 0);
    chk("rst_done", 32'(a_if.done_o), 0);
    chk("rst_st_en", 32'(a_if.st_en_o), 0);
    chk("rst_ld", 32'(a_if.ld_pt_o), 0);
    chk("rst_b_busy", 32'(b_if.busy_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 1: nominal run, no stalls
    begin_test();
    a_if.key_rdy_i = 1'b1;
    a_if.start_i   = 1'b1;
    at(1);
    a_if.start_i = 1'b0;
    at(60);
    chk("t1_done_cyc", first1(dn_a), 13);
    chk("t1_done_n", cnt1(dn_a, 0, 59), 1);
    chk("t1_st_n", cnt1(st_a, 0, 59), 11);
    chk("t1_st_first", first1(st_a), 2);
    chk("t1_st_2_12", cnt1(st_a, 2, 12), 11);
    chk("t1_ld1", 32'(ld_a[1]), 1);
    chk("t1_mix3", 32'(mx_a[3]), 1);
    chk("t1_mix11", 32'(mx_a[11]), 1);
    chk("t1_mix12", 32'(mx_a[12]), 0);
    chk("t1_mix_n", cnt1(mx_a, 0, 59), 9);
    chk("t1_rnd1", 32'(rnd_a[1]), 0);
    chk("t1_rnd2", 32'(rnd_a[2]), 0);
    chk("t1_rnd3", 32'(rnd_a[3]), 1);
    chk("t1_rnd12", 32'(rnd_a[12]), 10);
    chk("t1_rnd13", 32'(rnd_a[13]), 10);
    chk("t1_rnd14", 32'(rnd_a[14]), 0);

    // 2: key stalls at ARK0 (2 cycles) and round 5 (1 cycle)
    begin_test();
    a_if.start_i = 1'b1;
    at(1);
    a_if.start_i = 1'b0;
    at(2);
    a_if.key_rdy_i = 1'b0;
    at(4);
    a_if.key_rdy_i = 1'b1;
    at(9);
    a_if.key_rdy_i = 1'b0;
    at(10);
    a_if.key_rdy_i = 1'b1;
    at(60);
    chk("t2_done_cyc", first1(dn_a), 16);
    chk("t2_done_n", cnt1(dn_a, 0, 59), 1);
    chk("t2_st_n", cnt1(st_a, 0, 59), 11);
    chk("t2_st2", 32'(st_a[2]), 0);
    chk("t2_st3", 32'(st_a[3]), 0);
    chk("t2_st4", 32'(st_a[4]), 1);
    chk("t2_rnd3", 32'(rnd_a[3]), 0);
    chk("t2_rnd5", 32'(rnd_a[5]), 1);
    chk("t2_rnd9", 32'(rnd_a[9]), 5);
    chk("t2_rnd10", 32'(rnd_a[10]), 5);
    chk("t2_st9", 32'(st_a[9]), 0);
    chk("t2_st10", 32'(st_a[10]), 1);
    chk("t2_rnd11", 32'(rnd_a[11]), 6);

    // 3: RND_LAT=3 instance
    begin_test();
    b_if.key_rdy_i = 1'b1;
    b_if.start_i   = 1'b1;
    at(1);
    b_if.start_i = 1'b0;
    at(60);
    chk("t3_done_cyc", first1(dn_b), 33);
    chk("t3_done_n", cnt1(dn_b, 0, 59), 1);
    chk("t3_st_n", cnt1(st_b, 0, 59), 11);
    chk("t3_st3", 32'(st_b[3]), 0);
    chk("t3_st4", 32'(st_b[4]), 0);
    chk("t3_st5", 32'(st_b[5]), 1);
    chk("t3_st32", 32'(st_b[32]), 1);
    chk("t3_mix_3_5", cnt1(mx_b, 3, 5), 3);
    chk("t3_mix_n", cnt1(mx_b, 0, 59), 27);
    chk("t3_mix30", 32'(mx_b[30]), 0);
    chk("t3_rnd29", 32'(rnd_b[29]), 9);
    chk("t3_rnd30", 32'(rnd_b[30]), 10);

    // 4: abort in round 4, restart two cycles later
    begin_test();
    a_if.start_i = 1'b1;
    at(1);
    a_if.start_i = 1'b0;
    at(6);
    a_if.abort_i = 1'b1;
    at(7);
    a_if.abort_i = 1'b0;
    at(8);
    a_if.start_i = 1'b1;
    at(9);
    a_if.start_i = 1'b0;
    at(60);
    chk("t4_rnd6", 32'(rnd_a[6]), 4);
    chk("t4_st6", 32'(st_a[6]), 0);
    chk("t4_busy7", 32'(bz_a[7]), 0);
    chk("t4_rnd7", 32'(rnd_a[7]), 0);
    chk("t4_mix7", 32'(mx_a[7]), 0);
    chk("t4_done_cyc", first1(dn_a), 21);
    chk("t4_done_n", cnt1(dn_a, 0, 59), 1);
    chk("t4_st_n", cnt1(st_a, 0, 59), 15);

    // 5: start held high, back-to-back blocks
    begin_test();
    a_if.start_i = 1'b1;
    at(30);
    a_if.start_i = 1'b0;
    at(60);
    chk("t5_done13", 32'(dn_a[13]), 1);
    chk("t5_done26", 32'(dn_a[26]), 1);
    chk("t5_done39", 32'(dn_a[39]), 1);
    chk("t5_done_n", cnt1(dn_a, 0, 59), 3);
    chk("t5_ld14", 32'(ld_a[14]), 1);
    chk("t5_ld_n", cnt1(ld_a, 0, 59), 3);
    chk("t5_st_n", cnt1(st_a, 0, 59), 33);
    chk("t5_busy40", 32'(bz_a[40]), 0);

    // 6: reset with abort and start during the final round
    begin_test();
    a_if.start_i = 1'b1;
    at(1);
    a_if.start_i = 1'b0;
    at(12);
    rst          = 1'b1;
    a_if.abort_i = 1'b1;
    a_if.start_i = 1'b1;
    at(13);
    rst          = 1'b0;
    a_if.abort_i = 1'b0;
    a_if.start_i = 1'b0;
    at(60);
    chk("t6_rnd12", 32'(rnd_a[12]), 10);
    chk("t6_st12", 32'(st_a[12]), 0);
    chk("t6_rnd13", 32'(rnd_a[13]), 0);
    chk("t6_busy13", 32'(bz_a[13]), 0);
    chk("t6_ld13", 32'(ld_a[13]), 0);
    chk("t6_busy14", 32'(bz_a[14]), 0);
    chk("t6_done_n", cnt1(dn_a, 0, 59), 0);
    chk("t6_st_n", cnt1(st_a, 0, 59), 10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
